quadrature_decoder: RTL and testbench

Receive-side counterpart of the simulated motor encoder. Takes raw quadrature channels A/B from an encoder (real or simulated), synchronizes and glitch-filters them, and decodes every legal transition into a signed position count, direction, a one-cycle step strobe and a step-period measurement. Illegal double-edge transitions are flagged and counted. Sits between the encoder pins and the motor-control/register logic.

---
 rtl/quad_pkg.sv | 42 ++++
 rtl/quad_input_filter.sv | 55 +++++
 rtl/quadrature_decoder.sv | 165 ++++++++++++++++
 tb/tb_quadrature_decoder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared definitions for the quadrature decoder.
// The {A,B} channel pair steps through the Gray sequence 00 -> 10 -> 11 -> 01 -> 00 going forward
// (A leads B). Reverse motion walks the same ring in the opposite order.
package quad_pkg;

  localparam logic       DIR_FWD     = 1'b0;
  localparam logic       DIR_REV     = 1'b1;
  localparam logic [7:0] ERR_CNT_MAX = 8'hFF;

  // Classification of one prev -> curr transition of the filtered {A,B} pair.
  typedef enum logic [1:0] {
    MoveNone,
    MoveFwd,
    MoveRev,
    MoveIllegal
  } move_e;

  // Forward successor of a 2-bit {A,B} state.
  function automatic logic [1:0] fwd_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b10;
      2'b10:   nxt = 2'b11;
      2'b11:   nxt = 2'b01;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

  // Reverse successor of a 2-bit {A,B} state.
  function automatic logic [1:0] rev_next(input logic [1:0] ab);
    logic [1:0] nxt;
    unique case (ab)
      2'b00:   nxt = 2'b01;
      2'b01:   nxt = 2'b11;
      2'b11:   nxt = 2'b10;
      default: nxt = 2'b00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a persistence filter for one raw encoder channel.
// The filtered output only takes a new level once the synchronized input has differed from it
// for FILTER_LEN consecutive cycles; shorter pulses are discarded.
// Ports:
//   clk_i   system clock
//   rst_ni  asynchronous active-low reset
//   raw_i   raw channel, asynchronous to clk_i
//   filt_o  synchronized, glitch-filtered channel level
module quad_input_filter #(
  parameter int unsigned FILTER_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic filt_o
);

  localparam int unsigned CntW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(FILTER_LEN - 1);

  logic            sync1_q, sync2_q;
  logic            filt_q, filt_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      filt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    filt_d = filt_q;
    cnt_d  = cnt_q;
    if (sync2_q == filt_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntMax) begin
      // This is the FILTER_LEN-th consecutive cycle at the new level.
      filt_d = sync2_q;
      cnt_d  = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filters raw A/B encoder channels and turns every legal transition into a
// signed position count, direction, one-cycle step strobe and step-period measurement. Double-edge
// transitions are flagged and counted (saturating).
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   enable_i          decode enable; low freezes all counting outputs
//   clr_i             synchronous clear of position, err_cnt and period state
//   a_i, b_i          raw channels (asynchronous)
//   position_o        signed step count, wraps modulo 2^COUNT_WIDTH
//   dir_o             direction of last valid step (0 forward, 1 reverse)
//   step_o, err_o     one-cycle pulses per valid step / illegal transition
//   err_cnt_o         saturating illegal-transition count
//   period_o          clk cycles between the last two valid steps (saturating)
//   period_valid_o    period came from two consecutive same-direction steps
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned FILTER_LEN   = 4,
  parameter int unsigned PERIOD_WIDTH = 24
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    enable_i,
  input  logic                    clr_i,
  input  logic                    a_i,
  input  logic                    b_i,
  output logic [COUNT_WIDTH-1:0]  position_o,
  output logic                    dir_o,
  output logic                    step_o,
  output logic                    err_o,
  output logic [7:0]              err_cnt_o,
  output logic [PERIOD_WIDTH-1:0] period_o,
  output logic                    period_valid_o
);

  logic        a_filt, b_filt;
  logic [1:0]  curr_ab, prev_q;
  move_e       move;

  logic [COUNT_WIDTH-1:0]  position_q, position_d;
  logic                    dir_q, dir_d;
  logic                    step_q, step_d;
  logic                    err_q, err_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic [PERIOD_WIDTH-1:0] timer_q, timer_d, timer_inc;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;
  logic                    period_valid_q, period_valid_d;
  // Set once a valid step has been seen since reset/clear; gates period_valid.
  logic                    seen_step_q, seen_step_d;
  logic                    step_dir;

  quad_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .raw_i (a_i),
    .filt_o(a_filt)
  );

  quad_input_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_filt_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .raw_i (b_i),
    .filt_o(b_filt)
  );

  assign curr_ab = {a_filt, b_filt};

  always_comb begin
    if (curr_ab == prev_q) begin
      move = MoveNone;
    end else if (curr_ab == fwd_next(prev_q)) begin
      move = MoveFwd;
    end else if (curr_ab == rev_next(prev_q)) begin
      move = MoveRev;
    end else begin
      move = MoveIllegal;
    end
  end

  assign timer_inc = (timer_q == '1) ? timer_q : timer_q + PERIOD_WIDTH'(1);
  assign step_dir  = (move == MoveRev) ? DIR_REV : DIR_FWD;

  always_comb begin
    position_d     = position_q;
    dir_d          = dir_q;
    step_d         = 1'b0;
    err_d          = 1'b0;
    err_cnt_d      = err_cnt_q;
    timer_d        = timer_q;
    period_d       = period_q;
    period_valid_d = period_valid_q;
    seen_step_d    = seen_step_q;
    if (clr_i) begin
      // Clear wins over any simultaneous step or error; dir and period are kept.
      position_d     = '0;
      err_cnt_d      = '0;
      timer_d        = '0;
      period_valid_d = 1'b0;
      seen_step_d    = 1'b0;
    end else if (enable_i) begin
      timer_d = timer_inc;
      unique case (move)
        MoveFwd, MoveRev: begin
          step_d         = 1'b1;
          position_d     = (move == MoveFwd) ? position_q + COUNT_WIDTH'(1)
                                             : position_q - COUNT_WIDTH'(1);
          dir_d          = step_dir;
          period_d       = timer_inc;
          timer_d        = '0;
          period_valid_d = seen_step_q && (dir_q == step_dir);
          seen_step_d    = 1'b1;
        end
        MoveIllegal: begin
          err_d = 1'b1;
          if (err_cnt_q != ERR_CNT_MAX) begin
            err_cnt_d = err_cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q         <= 2'b00;
      position_q     <= '0;
      dir_q          <= DIR_FWD;
      step_q         <= 1'b0;
      err_q          <= 1'b0;
      err_cnt_q      <= '0;
      timer_q        <= '0;
      period_q       <= '0;
      period_valid_q <= 1'b0;
      seen_step_q    <= 1'b0;
    end else begin
      // prev follows the filtered pair unconditionally so that disabled periods never
      // produce a burst of catch-up steps.
      prev_q         <= curr_ab;
      position_q     <= position_d;
      dir_q          <= dir_d;
      step_q         <= step_d;
      err_q          <= err_d;
      err_cnt_q      <= err_cnt_d;
      timer_q        <= timer_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      seen_step_q    <= seen_step_d;
    end
  end

  assign position_o     = position_q;
  assign dir_o          = dir_q;
  assign step_o         = step_q;
  assign err_o          = err_q;
  assign err_cnt_o      = err_cnt_q;
  assign period_o       = period_q;
  assign period_valid_o = period_valid_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder (COUNT_WIDTH=8, PERIOD_WIDTH=8, FILTER_LEN=4). The reference model
// tracks the encoder as a phase 0..3 on the Gray ring and derives every expected output from the
// phase difference of each applied transition and the cycle at which it must be decoded.
module tb_quadrature_decoder;

  localparam int unsigned CW  = 8;
  localparam int unsigned FL  = 4;
  localparam int unsigned PW  = 8;
  localparam int          LAT = FL + 3;  // negedges from driving a pin to seeing the result
  localparam int          PMAX = (1 << PW) - 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b1;
  logic          enable_i = 1'b1;
  logic          clr_i = 1'b0;
  logic          a_i = 1'b0;
  logic          b_i = 1'b0;
  logic [CW-1:0] position_o;
  logic          dir_o, step_o, err_o, period_valid_o;
  logic [7:0]    err_cnt_o;
  logic [PW-1:0] period_o;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state.
  int         m_pos, m_errcnt, m_ref, m_period;
  logic       m_dir, m_pvalid;
  bit         m_have;
  logic [1:0] m_ab;
  logic [1:0] ab_of [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quadrature_decoder #(
    .COUNT_WIDTH (CW),
    .FILTER_LEN  (FL),
    .PERIOD_WIDTH(PW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .enable_i      (enable_i),
    .clr_i         (clr_i),
    .a_i           (a_i),
    .b_i           (b_i),
    .position_o    (position_o),
    .dir_o         (dir_o),
    .step_o        (step_o),
    .err_o         (err_o),
    .err_cnt_o     (err_cnt_o),
    .period_o      (period_o),
    .period_valid_o(period_valid_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic int phase(input logic [1:0] ab);
    for (int i = 0; i < 4; i++) if (ab_of[i] == ab) return i;
    return 0;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [1:0] ab);
    return ab_of[(phase(ab) + 1) % 4];
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] ab);
    return ab_of[(phase(ab) + 3) % 4];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic chk_state();
    chk("position", position_o, m_pos);
    chk("dir", dir_o, m_dir);
    chk("err_cnt", err_cnt_o, m_errcnt);
    chk("period", period_o, m_period);
    chk("period_valid", period_valid_o, m_pvalid);
  endtask

  // Model one transition to nab that the decoder acts on at clock edge number edge_cyc.
  task automatic model(input logic [1:0] nab, input int edge_cyc, input bit en, input bit clr,
                       inout int nstep, inout int nerr);
    int d;
    logic ndir;
    d    = (phase(nab) - phase(m_ab) + 4) % 4;
    m_ab = nab;
    if (clr) begin
      m_pos = 0; m_errcnt = 0; m_have = 0; m_pvalid = 0; m_ref = edge_cyc;
    end else if (en && d == 2) begin
      nerr++;
      m_errcnt = (m_errcnt < 255) ? m_errcnt + 1 : 255;
    end else if (en && d != 0) begin
      nstep++;
      ndir     = (d == 3);
      m_period = (edge_cyc - m_ref > PMAX) ? PMAX : edge_cyc - m_ref;
      m_pvalid = m_have && (m_dir == ndir);
      m_have   = 1;
      m_dir    = ndir;
      m_pos    = (m_pos + ((d == 1) ? 1 : -1)) & ((1 << CW) - 1);
      m_ref    = edge_cyc;
    end
  endtask

  // Drive the pins to ab (called on a negedge) and watch gap cycles; gap must be >= LAT.
  task automatic apply(input logic [1:0] ab, input int gap, input bit en, input bit clr_at);
    int c0, ns, ne, es, ee, idx;
    c0 = cyc; es = 0; ee = 0; ns = 0; ne = 0; idx = -1;
    enable_i   = en;
    {a_i, b_i} = ab;
    model(ab, c0 + LAT, en, clr_at, es, ee);
    for (int i = 1; i <= gap; i++) begin
      @(negedge clk_i);
      if (step_o === 1'b1) begin ns++; idx = i; end
      if (err_o === 1'b1) ne++;
      if (clr_at && i == LAT - 1) clr_i = 1'b1;
      if (i == LAT) clr_i = 1'b0;
    end
    if (!en) begin
      enable_i = 1'b1;
      m_ref += gap;  // the period timer did not run while disabled
    end
    chk("step_count", ns, es);
    chk("err_count", ne, ee);
    if (es != 0) chk("step_latency", idx, LAT);
    chk_state();
  endtask

  // Toggle A for width cycles and watch a fixed window.
  task automatic pulse_a(input int width);
    int c0, ns, ne, es, ee;
    logic [1:0] orig;
    c0 = cyc; orig = m_ab; ns = 0; ne = 0; es = 0; ee = 0;
    a_i = ~a_i;
    if (width >= FL) begin
      model(orig ^ 2'b10, c0 + LAT, 1, 0, es, ee);
      model(orig, c0 + width + LAT, 1, 0, es, ee);
    end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk_i);
      if (step_o === 1'b1) ns++;
      if (err_o === 1'b1) ne++;
      if (i == width) a_i = ~a_i;
    end
    chk("glitch_steps", ns, es);
    chk("glitch_errs", ne, ee);
    chk_state();
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0; a_i = 1'b0; b_i = 1'b0; enable_i = 1'b1; clr_i = 1'b0;
    #1;
    chk("rst_async_position", position_o, 0);
    repeat (3) @(negedge clk_i);
    chk("rst_position", position_o, 0);
    chk("rst_dir", dir_o, 0);
    chk("rst_step", step_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_err_cnt", err_cnt_o, 0);
    chk("rst_period", period_o, 0);
    chk("rst_period_valid", period_valid_o, 0);
    rst_ni   = 1'b1;
    m_pos    = 0; m_dir = 0; m_errcnt = 0; m_have = 0; m_period = 0; m_pvalid = 0;
    m_ab     = 2'b00;
    m_ref    = cyc;
  endtask

  initial begin
    int r;
    bit en, cl;
    do_reset();

    // Forward: 8 steps 20 cycles apart.
    for (int i = 0; i < 8; i++) apply(fwd_of(m_ab), 20, 1, 0);
    chk("fwd_position", position_o, 8);

    // Reverse then turn-around.
    do_reset();
    for (int i = 0; i < 3; i++) apply(rev_of(m_ab), 15, 1, 0);
    chk("rev_position", position_o, 8'hFD);
    apply(fwd_of(m_ab), 15, 1, 0);
    chk("turn_pvalid", period_valid_o, 0);

    // Glitch rejection and minimum-width pulse.
    pulse_a(3);
    pulse_a(4);

    // Illegal transitions and saturation of the error count.
    apply(m_ab ^ 2'b11, 10, 1, 0);
    for (int i = 0; i < 300; i++) apply(m_ab ^ 2'b11, 8, 1, 0);
    chk("err_saturated", err_cnt_o, 255);

    // Wrap at COUNT_WIDTH=8, then clear coinciding with a step.
    do_reset();
    for (int i = 0; i < 128; i++) apply(fwd_of(m_ab), 8, 1, 0);
    chk("wrap_position", position_o, 8'h80);
    apply(fwd_of(m_ab), 10, 1, 1);
    apply(fwd_of(m_ab), 10, 1, 0);

    // Stall: a 300-cycle gap saturates the period.
    apply(fwd_of(m_ab), 300, 1, 0);
    apply(fwd_of(m_ab), 10, 1, 0);
    chk("stall_period", period_o, PMAX);

    // Steps while disabled are dropped, with no catch-up afterwards.
    apply(fwd_of(m_ab), 12, 0, 0);
    apply(m_ab, 12, 1, 0);
    apply(fwd_of(m_ab), 15, 1, 0);

    // Randomized walk.
    for (int n = 0; n < 80; n++) begin
      r  = $urandom_range(0, 9);
      en = ($urandom_range(0, 11) != 0);
      cl = en && ($urandom_range(0, 15) == 0);
      if (r == 0)      apply(m_ab ^ 2'b11, $urandom_range(LAT + 1, 40), en, cl);
      else if (r < 5)  apply(fwd_of(m_ab), $urandom_range(LAT + 1, 40), en, cl);
      else if (r < 9)  apply(rev_of(m_ab), $urandom_range(LAT + 1, 40), en, cl);
      else             apply(m_ab, $urandom_range(LAT + 1, 40), en, cl);
    end

    // Reset in the middle of a transition, then decode relative to 00.
    a_i = ~a_i;
    repeat (3) @(negedge clk_i);
    do_reset();
    apply(2'b10, 12, 1, 0);
    chk("post_reset_position", position_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
